hv_wdg_timer: RTL

HV_WDG_TIMER -- requirements
Module: hv_wdg_timer

---
 rtl/hv_wdg_timer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/hv_wdg_timer.sv
// ============================================================================
// hv_wdg_timer
// ----------------------------------------------------------------------------
// Watchdog timer for the HV control path. A free-running prescaler divides
// i_clk into watchdog ticks; every tick advances a tick counter that must be
// refreshed (kicked) before it reaches the configured threshold. When the
// threshold is reached the block parks in TMO and raises a sticky error that
// the control FSM consumes as its watchdog timeout input.
//
// Parameters
//   WDG_CNT_W  width of the tick counter and of the timeout threshold
//   PRE_DIV    i_clk cycles per watchdog tick (must be >= 2)
//
// Ports
//   i_clk              sole clock, all state updates on the rising edge
//   i_rst              synchronous, active-high reset
//   i_wdg_scan_en      watchdog enable (high while the control FSM is in
//                      NML_ST/FAULT_ST); low forces IDLE with cleared counters
//   i_wdg_kick         single-cycle refresh pulse
//   i_wdg_tmo_cfg      timeout threshold in ticks, 0 disables the timeout
//   i_wdg_err_clr      single-cycle clear of the sticky timeout error
//   o_reg_wdg_tmo_err  sticky timeout error (registered)
//   o_wdg_cnt          current tick count (registered)
//   o_wdg_st           state: 0 IDLE, 1 RUN, 2 TMO (registered)
// ============================================================================
module hv_wdg_timer #(
    parameter int WDG_CNT_W = 16,
    parameter int PRE_DIV   = 100
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_wdg_scan_en,
    input  logic                 i_wdg_kick,
    input  logic [WDG_CNT_W-1:0] i_wdg_tmo_cfg,
    input  logic                 i_wdg_err_clr,
    output logic                 o_reg_wdg_tmo_err,
    output logic [WDG_CNT_W-1:0] o_wdg_cnt,
    output logic [1:0]           o_wdg_st
);

    // ------------------------------------------------------------------------
    // Local constants
    // ------------------------------------------------------------------------
    localparam int                   PRE_W    = (PRE_DIV > 2) ? $clog2(PRE_DIV) : 1;
    localparam logic [PRE_W-1:0]     PRE_LAST = PRE_W'(PRE_DIV - 1);
    localparam logic [PRE_W-1:0]     PRE_ONE  = PRE_W'(1);
    localparam logic [PRE_W-1:0]     PRE_ZERO = '0;
    localparam logic [WDG_CNT_W-1:0] CNT_ONE  = WDG_CNT_W'(1);
    localparam logic [WDG_CNT_W-1:0] CNT_ZERO = '0;

    // Encoding 2'd3 is unused; the default branch below returns it to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_TMO  = 2'd2
    } wdg_st_e;

    // ------------------------------------------------------------------------
    // State registers and next-state values
    // ------------------------------------------------------------------------
    wdg_st_e              st_q,  st_d;
    logic [PRE_W-1:0]     pre_q, pre_d;
    logic [WDG_CNT_W-1:0] cnt_q, cnt_d;
    logic                 err_q, err_d;

    // Timeout raised this cycle; used so that a coincident err_clr loses.
    logic                 err_set;

    // ------------------------------------------------------------------------
    // Helper decodes
    // ------------------------------------------------------------------------
    logic                 pre_tick;
    logic                 cfg_zero;
    logic [WDG_CNT_W-1:0] cfg_m1;
    logic                 cnt_at_limit;

    assign pre_tick = (pre_q == PRE_LAST);
    assign cfg_zero = (i_wdg_tmo_cfg == CNT_ZERO);
    assign cfg_m1   = i_wdg_tmo_cfg - CNT_ONE;

    // ">=" rather than "==": if the threshold is lowered below the current
    // count mid-run, the next tick still times out instead of letting the
    // counter run on and wrap.
    assign cnt_at_limit = (cnt_q >= cfg_m1);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default at the top of the block,
    // so no path through the case statement can leave it unassigned and infer
    // a latch.
    always_comb begin
        st_d    = st_q;
        pre_d   = pre_q;
        cnt_d   = cnt_q;
        err_set = 1'b0;

        if (!i_wdg_scan_en) begin
            // Disable outranks kick, tick, timeout and err_clr.
            st_d  = ST_IDLE;
            pre_d = PRE_ZERO;
            cnt_d = CNT_ZERO;
        end else begin
            case (st_q)
                ST_IDLE: begin
                    // Kick is ignored here; counters start from zero in RUN.
                    st_d  = ST_RUN;
                    pre_d = PRE_ZERO;
                    cnt_d = CNT_ZERO;
                end

                ST_RUN: begin
                    if (i_wdg_kick) begin
                        // Kick beats a coincident tick or timeout.
                        pre_d = PRE_ZERO;
                        cnt_d = CNT_ZERO;
                    end else if (cfg_zero) begin
                        // Timeout disabled: hold everything at zero so that
                        // enabling a threshold later starts a clean period.
                        pre_d = PRE_ZERO;
                        cnt_d = CNT_ZERO;
                    end else if (pre_tick) begin
                        pre_d = PRE_ZERO;
                        if (cnt_at_limit) begin
                            st_d    = ST_TMO;
                            cnt_d   = i_wdg_tmo_cfg;
                            err_set = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end else begin
                        pre_d = pre_q + PRE_ONE;
                    end
                end

                ST_TMO: begin
                    // Counters frozen, kick ignored; only err_clr leaves.
                    if (i_wdg_err_clr) begin
                        st_d  = ST_RUN;
                        pre_d = PRE_ZERO;
                        cnt_d = CNT_ZERO;
                    end
                end

                default: begin
                    st_d  = ST_IDLE;
                    pre_d = PRE_ZERO;
                    cnt_d = CNT_ZERO;
                end
            endcase
        end

        // Sticky error: a new timeout wins over a same-edge clear; otherwise
        // err_clr clears it in any state, and disable does not touch it.
        err_d = err_set | (err_q & ~i_wdg_err_clr);
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            st_q  <= ST_IDLE;
            pre_q <= PRE_ZERO;
            cnt_q <= CNT_ZERO;
            err_q <= 1'b0;
        end else begin
            st_q  <= st_d;
            pre_q <= pre_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: straight from flops, no input-to-output combinational path
    // ------------------------------------------------------------------------
    assign o_reg_wdg_tmo_err = err_q;
    assign o_wdg_cnt         = cnt_q;
    assign o_wdg_st          = st_q;

endmodule
